pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable, stall and flush controls of the PC and the IF/ID register, and the bubble control of ID/EX. It handles load-use stalls, taken-branch flushes and HALT draining, and provides run/step/halt execution modes for the debug unit. It also keeps cycle and stall counters that the debug unit reads.

---
 rtl/pipeline_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline sequencing for the 5-stage MIPS core.
// It handles load-use stalls, branch flushes, HALT draining, run/step modes and cycle/stall counters.
module pipeline_ctrl #(
    parameter int REGW      = 5,
    parameter int CNTW      = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_run,
    input  logic            i_step,
    input  logic [REGW-1:0] i_id_rs,
    input  logic [REGW-1:0] i_id_rt,
    input  logic [REGW-1:0] i_ex_rt,
    input  logic            i_ex_memread,
    input  logic            i_branch_taken,
    input  logic            i_id_halt,
    output logic            o_pipe_en,
    output logic            o_pc_write,
    output logic            o_ifid_write,
    output logic            o_ifid_flush,
    output logic            o_idex_bubble,
    output logic            o_halted,
    output logic [CNTW-1:0] o_cycle_cnt,
    output logic [CNTW-1:0] o_stall_cnt
);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [CNTW-1:0] cycle_q, stall_q;
    logic            active, load_use;

    assign active   = (state_q == RUN) || (state_q == STEP);
    assign load_use = i_ex_memread && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        o_pipe_en     = 1'b0;
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_halted      = 1'b0;
        unique case (state_q)
            IDLE: state_d = i_run ? RUN : i_step ? STEP : IDLE;
            RUN, STEP: begin
                o_pipe_en = 1'b1;
                state_d   = (state_q == STEP) ? IDLE : RUN;
                // Stall outranks branch and halt: the dependent instruction must hold in ID.
                if (load_use) begin
                    o_idex_bubble = 1'b1;
                end else if (i_branch_taken) begin
                    o_pc_write   = 1'b1;
                    o_ifid_write = 1'b1;
                    o_ifid_flush = 1'b1;
                end else if (i_id_halt) begin
                    o_ifid_flush = 1'b1;
                    state_d      = DRAIN;
                    drain_d      = DW'(DRAIN_CYC - 1);
                end else begin
                    o_pc_write   = 1'b1;
                    o_ifid_write = 1'b1;
                end
            end
            DRAIN: begin
                o_pipe_en     = 1'b1;
                o_ifid_flush  = 1'b1;
                o_idex_bubble = 1'b1;
                state_d       = (drain_q == '0) ? HALTED : DRAIN;
                drain_d       = (drain_q == '0) ? drain_q : drain_q - 1'b1;
            end
            HALTED: o_halted = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            drain_q <= '0;
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (o_pipe_en && !(&cycle_q))
                cycle_q <= cycle_q + 1'b1;
            if (active && load_use && !(&stall_q))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign o_cycle_cnt = cycle_q;
    assign o_stall_cnt = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl with a queue scoreboard of expected controls.
module tb_pipeline_ctrl;
    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_NORM   = 6'b111000;
    localparam logic [5:0] C_STALL  = 6'b100010;
    localparam logic [5:0] C_BRANCH = 6'b111100;
    localparam logic [5:0] C_HALTC  = 6'b100100;
    localparam logic [5:0] C_DRAIN  = 6'b100110;
    localparam logic [5:0] C_HALTED = 6'b000001;

    logic        clk = 1'b0;
    logic        rst, run, step, ex_memread, branch_taken, id_halt;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, halted;
    logic [31:0] cycle_cnt, stall_cnt;
    logic [5:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_step(step),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt),
        .i_ex_memread(ex_memread), .i_branch_taken(branch_taken), .i_id_halt(id_halt),
        .o_pipe_en(pipe_en), .o_pc_write(pc_write), .o_ifid_write(ifid_write),
        .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble), .o_halted(halted),
        .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
    );

    task automatic cmp(input string tag, input logic [5:0] exp);
        logic [5:0] obs, want;
        exp_q.push_back(exp);
        #2;
        obs  = {pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, halted};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: controls got %b expected %b", tag, obs, want);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cnt(input string tag, input int cyc, input int stl);
        checks++;
        assert (cycle_cnt === 32'(cyc)) else begin
            errors++;
            $error("FAIL %s cycle_cnt: got %0d expected %0d", tag, cycle_cnt, cyc);
        end
        checks++;
        assert (stall_cnt === 32'(stl)) else begin
            errors++;
            $error("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, stl);
        end
    endtask

    task automatic hz(input logic mr, input logic [4:0] er, input logic [4:0] rs,
                      input logic [4:0] rt, input logic br, input logic ht);
        ex_memread = mr; ex_rt = er; id_rs = rs; id_rt = rt;
        branch_taken = br; id_halt = ht;
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; step = 1'b0;
        hz(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset", C_IDLE);
        cnt("reset", 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cmp("idle", C_IDLE);
        cnt("idle", 0, 0);

        run = 1'b1;
        cmp("idle_run_req", C_IDLE);
        cmp("run_normal", C_NORM);
        hz(1, 8, 8, 0, 0, 0);
        cmp("load_use_rs", C_STALL);
        cnt("load_use_rs", 2, 1);
        hz(0, 8, 8, 0, 0, 0);
        cmp("after_stall", C_NORM);
        hz(1, 0, 0, 0, 0, 0);
        cmp("rt_zero_no_stall", C_NORM);
        cnt("rt_zero_no_stall", 4, 1);
        hz(1, 5, 1, 5, 0, 0);
        cmp("load_use_rt", C_STALL);
        hz(0, 0, 0, 0, 1, 0);
        cmp("branch", C_BRANCH);
        cnt("branch", 6, 2);
        hz(1, 8, 8, 0, 1, 0);
        cmp("branch_vs_stall", C_STALL);
        hz(1, 8, 8, 0, 0, 1);
        cmp("halt_vs_stall", C_STALL);
        cnt("halt_vs_stall", 8, 4);
        hz(0, 0, 0, 0, 0, 0);
        cmp("still_run", C_NORM);

        rst = 1'b0;
        cmp("reset_in_run", C_NORM);
        cnt("reset_in_run", 0, 0);
        rst = 1'b1; run = 1'b0; step = 1'b1;
        cmp("step_req", C_IDLE);
        step = 1'b0;
        cmp("step_cycle", C_NORM);
        cmp("step_back_idle", C_IDLE);
        cnt("step", 1, 0);
        step = 1'b1;
        cmp("step2_req", C_IDLE);
        step = 1'b0;
        hz(1, 8, 8, 0, 0, 0);
        cmp("step_stall", C_STALL);
        cmp("step_stall_idle", C_IDLE);
        cnt("step_stall", 2, 1);
        hz(0, 0, 0, 0, 0, 0);
        run = 1'b1; step = 1'b1;
        cmp("run_step_req", C_IDLE);
        run = 1'b0; step = 1'b0;
        cmp("run_prio_1", C_NORM);
        cmp("run_prio_2", C_NORM);
        cnt("run_prio", 4, 1);

        hz(0, 0, 0, 0, 0, 1);
        cmp("halt_cycle", C_HALTC);
        hz(1, 8, 8, 0, 1, 0);
        run = 1'b1; step = 1'b1;
        for (int i = 0; i < 3; i++) cmp("drain", C_DRAIN);
        cmp("halted_1", C_HALTED);
        cmp("halted_2", C_HALTED);
        cnt("halted", 8, 1);

        hz(0, 0, 0, 0, 0, 0);
        run = 1'b0; step = 1'b0; rst = 1'b0;
        cmp("reset_halted", C_HALTED);
        rst = 1'b1; run = 1'b1;
        cmp("md_run_req", C_IDLE);
        run = 1'b0;
        cmp("md_normal", C_NORM);
        id_halt = 1'b1;
        cmp("md_halt", C_HALTC);
        id_halt = 1'b0;
        cmp("md_drain1", C_DRAIN);
        rst = 1'b0;
        cmp("md_drain2_rst", C_DRAIN);
        rst = 1'b1;
        cmp("md_idle", C_IDLE);
        cnt("md_idle", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
